fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- IF-stage program-counter and redirect controller.
- Consumes the EX-stage branch/jump resolution (taken flag plus target) and steers instruction fetch.
- Generates pipeline flush signals and sequences the instruction-memory request handshake, including redirects that arrive while a fetch is outstanding.
- Sits between the EX-stage resolver, the load-use stall logic and the instruction memory.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- redirect_valid  in  1  EX-stage taken indication (branch condition true, JAL, JALR); single-cycle pulse per resolved instruction.
- redirect_target  in  32  EX-stage computed target; valid when redirect_valid=1.
- stall  in  1  load-use hold from decode; freezes the PC.
- imem_ready  in  1  instruction memory completes the current request this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- pc  out  32  current fetch PC.
- if_npc  out  32  pc+4 of the instruction delivered this cycle.
- if_valid  out  1  fetched word this cycle is architecturally valid; IF/ID captures it.
- flush_if_id  out  1  kill IF/ID contents at this edge.
- flush_id_ex  out  1  kill ID/EX contents at this edge.
- misalign_err  out  1  sticky: a redirect target had target[1:0]!=0.
- redirect_count  out  CNT_W  number of accepted redirects, saturating.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_PC, state=BOOT, pending register cleared.
  - imem_req=0, if_valid=0, flushes=0, misalign_err=0, redirect_count=0.
- States:
  - BOOT: one cycle, imem_req=0; next state RUN.
  - RUN: imem_req=!stall.
  - PEND: a redirect is latched while a request is outstanding; imem_req=1 at the old pc.
- Handshake:
  - Once imem_req=1 with imem_ready=0, imem_addr must stay stable until imem_ready=1. A transaction completes on the cycle both are high.
  - pc advances only at a completing edge.
- RUN, no redirect:
  - imem_ready=1 and stall=0: if_valid=1, if_npc=pc+4, pc<=pc+4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
  - imem_ready=0: pc holds, if_valid=0.
  - stall=1: imem_req=0, pc holds, if_valid=0.
- Redirect accepted (redirect_valid=1 in RUN or PEND):
  - Same cycle: flush_if_id=1 and flush_id_ex=1 (combinational), if_valid=0.
  - redirect_count increments, saturating at all-ones.
  - If redirect_target[1:0]!=0, misalign_err<=1. The applied target is always {redirect_target[31:2],2'b00}.
  - RUN and (imem_ready=1 or imem_req=0): pc<=aligned target next edge; stay in RUN.
  - RUN and imem_req=1 and imem_ready=0: latch the aligned target into pending; pc holds; go to PEND.
- PEND:
  - On imem_ready=1: fetched word discarded (if_valid=0), pc<=pending, go to RUN.
  - A newer redirect in PEND overwrites pending and raises flushes again; counter increments.
  - stall is ignored in PEND.
- Priority and simultaneous events:
  - redirect_valid beats stall: the stalled instruction in ID is younger and gets flushed.
  - redirect plus imem_ready in the same RUN cycle: the returned word is discarded, pc<=target.
- if_npc is the delivered word's pc+4 whenever if_valid=1; otherwise it is don't-care but driven.
- Reset mid-transaction: all state drops immediately, pending is lost, and fetch restarts from RESET_PC after BOOT.

Test Plan:
- Reset release, imem_ready tied 1 -> imem_req=0 for the first cycle, then imem_addr sequence 0,4,8,C with if_valid=1 each cycle and if_npc=4,8,C,10.
- At pc=0x10 with ready=1, pulse redirect_valid, target=0x200 -> flush_if_id=flush_id_ex=1 that cycle, if_valid=0, next imem_addr=0x200, redirect_count=1.
- Hold ready=0 at pc=0x20, redirect to 0x300, ready stays 0 for 3 cycles -> imem_addr stays 0x20 throughout; on ready=1 the word is discarded; next addr=0x300.
- stall=1 and redirect_valid=1 in the same cycle, target 0x80 -> redirect wins, flushes asserted, next pc=0x80; stall alone afterward holds 0x80 with imem_req=0.
- Redirect target 0x00000146 -> pc=0x144 and misalign_err=1, still 1 after further redirects until reset.
- Force 2^CNT_W+3 redirects -> redirect_count saturates at 0xFFFF. Also start from pc=0xFFFFFFFC with ready=1 -> next pc=0x0.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: IF-stage PC sequencing, redirect/flush control and imem handshake
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      if_npc,
  output logic             if_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count
);
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  state_t state, state_nx;
  logic [31:0] pending, tgt;
  logic accept, hold;
  // fsm state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nx;
  // request/flush decode and next state; hold means the request stays outstanding past this edge
  always_comb begin
    imem_req    = state == PEND || (state == RUN && !stall);
    accept      = redirect_valid && state != BOOT;
    hold        = imem_req && !imem_ready;
    if_valid    = state == RUN && imem_req && imem_ready && !redirect_valid;
    flush_if_id = accept;
    flush_id_ex = accept;
    tgt         = {redirect_target[31:2], 2'b00};
    state_nx    = state == BOOT ? RUN : ((accept || state == PEND) && hold) ? PEND : RUN;
  end
  // pc, pending target, sticky misalign flag and saturating redirect counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc             <= RESET_PC;
      pending        <= '0;
      misalign_err   <= 1'b0;
      redirect_count <= '0;
    end else begin
      if (accept && hold) pending <= tgt;
      if (accept && !hold) pc <= tgt;
      else if (state == PEND && !hold) pc <= pending;
      else if (if_valid) pc <= pc + 32'd4;
      if (accept && redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
      if (accept && !(&redirect_count)) redirect_count <= redirect_count + CNT_W'(1);
    end
  assign imem_addr = pc;
  assign if_npc    = pc + 32'd4;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: randomized scoreboard bench against a behavioural fetch model
module tb_fetch_redirect_unit;
  localparam logic [31:0] RPC = 32'h00000000;
  logic clk = 0, rst_n = 0, rv = 0, st = 0, rdy = 0;
  logic [31:0] rt = 0;
  logic imem_req, if_valid, flush_if_id, flush_id_ex, misalign_err;
  logic [31:0] imem_addr, pc, if_npc;
  logic [15:0] redirect_count;
  typedef struct {
    logic req; logic [31:0] pc; logic ifv; logic [31:0] npc;
    logic fl; logic mis; logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  logic [31:0] m_pc = RPC, m_ptgt = 0;
  bit m_boot = 1, m_pend = 0, m_mis = 0;
  int m_cnt = 0;

  fetch_redirect_unit #(.RESET_PC(RPC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(rv), .redirect_target(rt),
    .stall(st), .imem_ready(rdy), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .if_npc(if_npc), .if_valid(if_valid), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .misalign_err(misalign_err), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  // monitor: pop the expected response for each presented cycle and compare
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_req", 32'(imem_req), 32'(e.req));
      chk("imem_addr", imem_addr, e.pc);
      chk("pc", pc, e.pc);
      chk("if_valid", 32'(if_valid), 32'(e.ifv));
      chk("flush_if_id", 32'(flush_if_id), 32'(e.fl));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(e.fl));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("redirect_count", 32'(redirect_count), 32'(e.cnt));
      if (e.ifv) chk("if_npc", if_npc, e.npc);
    end

  task automatic cyc(bit rn, bit r, logic [31:0] t, bit s, bit y);
    exp_t e;
    bit acc;
    logic [31:0] ta;
    @(posedge clk);
    #1;
    rst_n = rn; rv = r; rt = t; st = s; rdy = y;
    if (!rn) begin
      m_pc = RPC; m_boot = 1; m_pend = 0; m_mis = 0; m_cnt = 0;
    end
    e.req = rn && !m_boot && (m_pend || !s);
    acc   = rn && !m_boot && r;
    e.ifv = e.req && !m_pend && y && !r;
    e.pc  = m_pc;
    e.npc = m_pc + 32'd4;
    e.fl  = acc;
    e.mis = m_mis;
    e.cnt = 16'(m_cnt);
    q.push_back(e);
    if (rn) begin
      ta = {t[31:2], 2'b00};
      if (acc) begin
        if (m_cnt < 65535) m_cnt++;
        if (t[1:0] != 2'b00) m_mis = 1;
        if (e.req && !y) begin m_pend = 1; m_ptgt = ta; end
        else begin m_pc = ta; m_pend = 0; end
      end else if (m_pend && y) begin
        m_pc = m_ptgt; m_pend = 0;
      end else if (e.ifv) m_pc = m_pc + 32'd4;
      m_boot = 0;
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h200, 0, 1);
    cyc(1, 1, 32'h20, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h300, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h80, 1, 1);
    repeat (3) cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h146, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h1000, 0, 0);
    cyc(1, 1, 32'h2000, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'hFFFFFFFC, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h400, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 1);
    repeat (3000)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
          ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC),
          $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    repeat (65540)
      cyc(1, 1, $urandom & 32'hFFFFFFFC, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    repeat (20)
      cyc(1, $urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
